// File: rtl/ila_dump_pkg.sv
// Shared definitions for the ILA buffer dump engine: FSM state encoding and
// the word-select width helper.
package ila_dump_pkg;

  // Dump FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_FETCH  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SEND   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Width of the word-select counter; never narrower than one bit
  function automatic int unsigned sel_width(input int unsigned nsel);
    return (nsel <= 1) ? 1 : $clog2(nsel);
  endfunction

endpackage

// File: rtl/ila_dump.sv
// ila_dump: streams the contents of an ILA sample buffer out as a header beat
// (sample count) followed by every buffer entry, one DATA_W word at a time,
// least-significant word first.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle dump request (ignored while busy)
//   samples          number of valid buffer entries, latched at start
//   index            buffer entry address to the sampler
//   value_select     word select within the entry to the sampler
//   value            sampler read data, valid one cycle after address change
//   m_valid/m_ready  output stream handshake
//   m_data, m_last   output stream payload and end-of-dump marker
//   busy             dump in progress
//   done             one-cycle pulse after the final beat handshake
module ila_dump
  import ila_dump_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BUFFER_W = 8,
  parameter int unsigned SIGNAL_W = 64,
  localparam int unsigned NSEL    = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int unsigned SEL_W   = sel_width(NSEL)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUFFER_W-1:0] samples,
  output logic [BUFFER_W-1:0] index,
  output logic [SEL_W-1:0]    value_select,
  input  logic [DATA_W-1:0]   value,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_last,
  output logic                busy,
  output logic                done
);

  state_e              r_state,  w_state_n;
  logic [BUFFER_W-1:0] r_n,      w_n_n;
  logic [BUFFER_W-1:0] r_index,  w_index_n;
  logic [SEL_W-1:0]    r_sel,    w_sel_n;
  logic                r_valid,  w_valid_n;
  logic [DATA_W-1:0]   r_data,   w_data_n;
  logic                r_last,   w_last_n;
  logic                r_busy,   w_busy_n;
  logic                r_done,   w_done_n;

  logic w_hs;
  logic w_sel_wrap;
  logic w_is_last;

  assign w_hs       = r_valid & m_ready;
  assign w_sel_wrap = (r_sel == SEL_W'(NSEL - 1));
  // Final beat: last word of the last valid entry
  assign w_is_last  = w_sel_wrap && (r_index == (r_n - BUFFER_W'(1)));

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_index <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_n     <= w_n_n;
      r_index <= w_index_n;
      r_sel   <= w_sel_n;
      r_valid <= w_valid_n;
      r_data  <= w_data_n;
      r_last  <= w_last_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_n = r_state;
    w_n_n     = r_n;
    w_index_n = r_index;
    w_sel_n   = r_sel;
    w_valid_n = r_valid;
    w_data_n  = r_data;
    w_last_n  = r_last;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_n_n     = samples;
          w_index_n = '0;
          w_sel_n   = '0;
          w_valid_n = 1'b1;
          w_data_n  = DATA_W'(samples);
          w_last_n  = (samples == '0);
          w_busy_n  = 1'b1;
          w_state_n = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (w_hs) begin
          w_valid_n = 1'b0;
          w_last_n  = 1'b0;
          if (r_n != '0) begin
            w_state_n = ST_FETCH;
          end else begin
            w_done_n  = 1'b1;
            w_state_n = ST_DONE;
          end
        end
      end

      // Address is on index/value_select; sampler registers it this cycle
      ST_FETCH: begin
        w_state_n = ST_WAIT;
      end

      // Sampler data is valid now; capture it into the beat register
      ST_WAIT: begin
        w_data_n  = value;
        w_last_n  = w_is_last;
        w_valid_n = 1'b1;
        w_state_n = ST_SEND;
      end

      ST_SEND: begin
        if (w_hs) begin
          w_valid_n = 1'b0;
          w_last_n  = 1'b0;
          if (r_last) begin
            w_done_n  = 1'b1;
            w_state_n = ST_DONE;
          end else begin
            if (w_sel_wrap) begin
              w_sel_n   = '0;
              w_index_n = r_index + BUFFER_W'(1);
            end else begin
              w_sel_n = r_sel + SEL_W'(1);
            end
            w_state_n = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        w_busy_n  = 1'b0;
        w_state_n = ST_IDLE;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign index        = r_index;
  assign value_select = r_sel;
  assign m_valid      = r_valid;
  assign m_data       = r_data;
  assign m_last       = r_last;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
